// File: rtl/cpu_datapath.sv
// cpu_datapath: execution datapath of the 8-bit microcoded CPU.
// It takes one control word per clock. It owns the shared bus, PC, MAR, the 16x8 RAM,
// IR, A, B, the adder/subtractor with its flags, the output register and the halt latch.
// Control lines change on the falling edge, and every register here updates on the rising edge.
module cpu_datapath #(
   parameter int RAM_DEPTH = 16,
   parameter int BUS_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hlt,
   input  logic             mi,
   input  logic             ri,
   input  logic             ro,
   input  logic             io,
   input  logic             ii,
   input  logic             ai,
   input  logic             ao,
   input  logic             sumo,
   input  logic             sub,
   input  logic             bi,
   input  logic             oi,
   input  logic             ce,
   input  logic             co,
   input  logic             j,
   input  logic             prog_we,
   input  logic [3:0]       prog_addr,
   input  logic [BUS_W-1:0] prog_data,
   output logic [BUS_W-1:0] insn,
   output logic [BUS_W-1:0] bus,
   output logic [BUS_W-1:0] out_val,
   output logic             out_valid,
   output logic             flag_c,
   output logic             flag_z,
   output logic             halted,
   output logic             bus_conflict
);

   localparam int AW = 4;

   logic [AW-1:0]    r_pc;
   logic [AW-1:0]    r_mar;
   logic [BUS_W-1:0] r_ir;
   logic [BUS_W-1:0] r_a;
   logic [BUS_W-1:0] r_b;
   logic [BUS_W-1:0] r_out;
   logic             r_out_valid;
   logic             r_flag_c;
   logic             r_flag_z;
   logic             r_halted;
   logic [BUS_W-1:0] r_ram [RAM_DEPTH];

   logic [BUS_W-1:0] w_bus;
   logic [BUS_W-1:0] w_ram_rd;
   logic [BUS_W-1:0] w_alu_res;
   logic             w_alu_carry;
   logic [2:0]       w_drv_cnt;
   logic             w_conflict;
   logic             w_active;

   // The adder and subtractor share one carry chain.
   // Subtraction adds the inverted operand plus one, so carry=1 means "no borrow".
   function automatic logic [BUS_W:0] alu_addsub(input logic [BUS_W-1:0] a_in,
                                                  input logic [BUS_W-1:0] b_in,
                                                  input logic             s_in);
      logic [BUS_W-1:0] b_op;
      b_op = s_in ? ~b_in : b_in;
      return {1'b0, a_in} + {1'b0, b_op} + {{BUS_W{1'b0}}, s_in};
   endfunction

   // Once halted, the block ignores every control line until reset.
   assign w_active = ~r_halted;

   // RAM is read asynchronously at the current MAR.
   assign w_ram_rd = r_ram[r_mar];

   assign {w_alu_carry, w_alu_res} = alu_addsub(r_a, r_b, sub);

   // Bus mux: fixed priority co > ro > io > ao > sumo; undriven or halted reads as zero.
   always_comb begin
      w_bus = '0;
      if (w_active) begin
         if (co)        w_bus = {{(BUS_W-AW){1'b0}}, r_pc};
         else if (ro)   w_bus = w_ram_rd;
         else if (io)   w_bus = {{(BUS_W-AW){1'b0}}, r_ir[AW-1:0]};
         else if (ao)   w_bus = r_a;
         else if (sumo) w_bus = w_alu_res;
      end
   end

   // Count the bus drivers so that overlapping enables in the microcode can be flagged.
   always_comb begin
      w_drv_cnt = {2'b00, co} + {2'b00, ro} + {2'b00, io} + {2'b00, ao} + {2'b00, sumo};
   end

   assign w_conflict = w_active & (w_drv_cnt > 3'd1);

   // Program counter: j loads from the bus and takes precedence over increment.
   // The increment wraps naturally in 4 bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else if (w_active) begin
         if (j)       r_pc <= w_bus[AW-1:0];
         else if (ce) r_pc <= r_pc + 4'd1;
      end
   end

   // Bus-loaded registers: MAR, IR, A, B. All of them sample the pre-edge bus.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mar <= '0;
         r_ir  <= '0;
         r_a   <= '0;
         r_b   <= '0;
      end else if (w_active) begin
         if (mi) r_mar <= w_bus[AW-1:0];
         if (ii) r_ir  <= w_bus;
         if (ai) r_a   <= w_bus;
         if (bi) r_b   <= w_bus;
      end
   end

   // ALU flags are captured only in cycles that put the sum on the bus, and hold otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flag_c <= 1'b0;
         r_flag_z <= 1'b0;
      end else if (w_active && sumo) begin
         r_flag_c <= w_alu_carry;
         r_flag_z <= (w_alu_res == '0);
      end
   end

   // Output register; out_valid pulses for exactly the cycle after each oi.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_active && oi) begin
            r_out       <= w_bus;
            r_out_valid <= 1'b1;
         end
      end
   end

   // Sticky halt latch; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_halted <= 1'b0;
      end else if (w_active && hlt) begin
         r_halted <= 1'b1;
      end
   end

   // RAM write port. The loader always has priority and keeps working while halted or in reset.
   // A microcode ri write needs the block to be running and out of reset.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         r_ram[prog_addr] <= prog_data;
      end else if (rst_n && w_active && ri) begin
         r_ram[r_mar] <= w_bus;
      end
   end

   assign insn         = r_ir;
   assign bus          = w_bus;
   assign out_val      = r_out;
   assign out_valid    = r_out_valid;
   assign flag_c       = r_flag_c;
   assign flag_z       = r_flag_z;
   assign halted       = r_halted;
   assign bus_conflict = w_conflict;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: bench for cpu_datapath.
// It uses hand-derived vector tables and directed sequences, followed by random control words.
// A behavioural reference model tracks the architectural state and scores every cycle.
module tb_cpu_datapath;

   typedef struct packed {
      logic hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j;
   } ctl_t;

   localparam logic [14:0] K_HLT  = 15'h4000;
   localparam logic [14:0] K_MI   = 15'h2000;
   localparam logic [14:0] K_RI   = 15'h1000;
   localparam logic [14:0] K_RO   = 15'h0800;
   localparam logic [14:0] K_IO   = 15'h0400;
   localparam logic [14:0] K_II   = 15'h0200;
   localparam logic [14:0] K_AI   = 15'h0100;
   localparam logic [14:0] K_AO   = 15'h0080;
   localparam logic [14:0] K_SUMO = 15'h0040;
   localparam logic [14:0] K_SUB  = 15'h0020;
   localparam logic [14:0] K_BI   = 15'h0010;
   localparam logic [14:0] K_OI   = 15'h0008;
   localparam logic [14:0] K_CE   = 15'h0004;
   localparam logic [14:0] K_CO   = 15'h0002;
   localparam logic [14:0] K_J    = 15'h0001;

   typedef struct {
      logic [14:0] cw;
      logic [7:0]  exp_bus;
      logic [7:0]  exp_insn;
      logic [7:0]  exp_out;
      logic        exp_ov;
      logic        exp_c;
      logic        exp_z;
      logic        exp_halt;
   } vec_t;

   logic       clk;
   logic       rst_n;
   ctl_t       cw;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [7:0] insn, bus, out_val;
   logic       out_valid, flag_c, flag_z, halted, bus_conflict;

   int n_tests;
   int n_fail;
   logic [7:0] last_bus;
   logic       last_conf;

   // reference model state
   logic [3:0] m_pc, m_mar;
   logic [7:0] m_ir, m_a, m_b, m_out;
   logic       m_ov, m_c, m_z, m_halt;
   logic [7:0] m_ram [16];

   cpu_datapath #(.RAM_DEPTH(16), .BUS_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .hlt(cw.hlt), .mi(cw.mi), .ri(cw.ri), .ro(cw.ro), .io(cw.io), .ii(cw.ii),
      .ai(cw.ai), .ao(cw.ao), .sumo(cw.sumo), .sub(cw.sub), .bi(cw.bi), .oi(cw.oi),
      .ce(cw.ce), .co(cw.co), .j(cw.j),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .insn(insn), .bus(bus), .out_val(out_val), .out_valid(out_valid),
      .flag_c(flag_c), .flag_z(flag_z), .halted(halted), .bus_conflict(bus_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Sum or difference from plain integer arithmetic; bit 8 is the carry (no-borrow when subtracting).
   function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b, input logic s);
      int t;
      t = s ? (int'(a) + 256 - int'(b)) : (int'(a) + int'(b));
      return 9'(t);
   endfunction

   function automatic logic [7:0] model_bus(input ctl_t c);
      logic [7:0] src [5];
      logic       en  [5];
      logic [8:0] s;
      s = model_sum(m_a, m_b, c.sub);
      src = '{{4'h0, m_pc}, m_ram[m_mar], {4'h0, m_ir[3:0]}, m_a, s[7:0]};
      en  = '{c.co, c.ro, c.io, c.ao, c.sumo};
      if (m_halt) return 8'h00;
      for (int k = 0; k < 5; k++) if (en[k]) return src[k];
      return 8'h00;
   endfunction

   function automatic logic model_conf(input ctl_t c);
      int n;
      n = int'(c.co) + int'(c.ro) + int'(c.io) + int'(c.ao) + int'(c.sumo);
      return !m_halt && (n > 1);
   endfunction

   task automatic model_step(input ctl_t c, input logic pwe, input logic [3:0] pa,
                             input logic [7:0] pd, input logic rn);
      logic [7:0] b;
      logic [8:0] s;
      b = model_bus(c);
      s = model_sum(m_a, m_b, c.sub);
      if (pwe) m_ram[pa] = pd;
      else if (rn && !m_halt && c.ri) m_ram[m_mar] = b;
      if (!rn) begin
         m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
         m_ov = 0; m_c = 0; m_z = 0; m_halt = 0;
      end else if (m_halt) begin
         m_ov = 0;
      end else begin
         if (c.mi) m_mar = b[3:0];
         if (c.ii) m_ir = b;
         if (c.ai) m_a = b;
         if (c.bi) m_b = b;
         m_ov = c.oi;
         if (c.oi) m_out = b;
         if (c.sumo) begin
            m_c = s[8];
            m_z = (s[7:0] == 8'h00);
         end
         if (c.j) m_pc = b[3:0];
         else if (c.ce) m_pc = 4'((int'(m_pc) + 1) % 16);
         if (c.hlt) m_halt = 1;
      end
   endtask

   // One clock: drive at the falling edge, score the bus before the rising edge, score the registers after it.
   task automatic cycle(input logic [14:0] c, input logic pwe, input logic [3:0] pa,
                        input logic [7:0] pd, input logic rn, input bit chk);
      ctl_t cc;
      cc = ctl_t'(c);
      @(negedge clk);
      cw = cc; prog_we = pwe; prog_addr = pa; prog_data = pd; rst_n = rn;
      #1;
      last_bus  = bus;
      last_conf = bus_conflict;
      if (chk) begin
         check("model.bus", bus, model_bus(cc));
         check("model.conflict", bus_conflict, model_conf(cc));
      end
      model_step(cc, pwe, pa, pd, rn);
      @(posedge clk);
      #1;
      if (chk) begin
         check("model.insn", insn, m_ir);
         check("model.out_val", out_val, m_out);
         check("model.out_valid", out_valid, m_ov);
         check("model.flag_c", flag_c, m_c);
         check("model.flag_z", flag_z, m_z);
         check("model.halted", halted, m_halt);
      end
   endtask

   task automatic idle(input logic [14:0] c);
      cycle(c, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1);
   endtask

   task automatic poke_ram(input logic [3:0] addr, input logic [7:0] d);
      cycle(15'h0, 1'b1, addr, d, 1'b1, 1'b1);
   endtask

   // Place a value at the current MAR, then move it into a register with ro plus the given load.
   task automatic load_via_ram(input logic [14:0] ld, input logic [7:0] v);
      poke_ram(m_mar, v);
      idle(K_RO | ld);
   endtask

   vec_t tbl [17];

   initial begin
      n_tests = 0; n_fail = 0;
      cw = '0; prog_we = 0; prog_addr = 0; prog_data = 0; rst_n = 0;
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
      m_ov = 0; m_c = 0; m_z = 0; m_halt = 0;
      for (int k = 0; k < 16; k++) m_ram[k] = 8'h00;

      // Program run: LDA 14, ADD 15, OUT, HLT (28 + 14 = 42).
      tbl[0]  = '{K_CO | K_MI,        8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{K_RO | K_II | K_CE, 8'h1E, 8'h1E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{K_IO | K_MI,        8'h0E, 8'h1E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{K_RO | K_AI,        8'h1C, 8'h1E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{K_CO | K_MI,        8'h01, 8'h1E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{K_RO | K_II | K_CE, 8'h2F, 8'h2F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{K_IO | K_MI,        8'h0F, 8'h2F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{K_RO | K_BI,        8'h0E, 8'h2F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{K_SUMO | K_AI,      8'h2A, 8'h2F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{K_CO | K_MI,        8'h02, 8'h2F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{K_RO | K_II | K_CE, 8'hE0, 8'hE0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{K_AO | K_OI,        8'h2A, 8'hE0, 8'h2A, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{K_CO | K_MI,        8'h03, 8'hE0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{K_RO | K_II | K_CE, 8'hF0, 8'hF0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{K_CO,               8'h04, 8'hF0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{K_HLT,              8'h00, 8'hF0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{K_CO | K_MI,        8'h00, 8'hF0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b1};

      // Bring-up: reset, then define every RAM word so the model and the design agree.
      cycle(15'h0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) poke_ram(4'(k), 8'(k * 29 + 7));

      // Reset test: dirty the state, then reset while ai and the bus are active.
      poke_ram(4'h0, 8'h5A);
      idle(K_RO | K_AI | K_II | K_CE);
      cycle(K_RO | K_AI, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
      check("rst.insn", insn, 8'h00);
      check("rst.out_val", out_val, 8'h00);
      check("rst.halted", halted, 1'b0);
      check("rst.out_valid", out_valid, 1'b0);
      idle(K_AO);  check("rst.a", last_bus, 8'h00);
      idle(K_CO);  check("rst.pc", last_bus, 8'h00);
      idle(K_RO);  check("rst.ram_kept", last_bus, 8'h5A);

      // Program run from the table.
      poke_ram(4'h0, 8'h1E); poke_ram(4'h1, 8'h2F); poke_ram(4'h2, 8'hE0);
      poke_ram(4'h3, 8'hF0); poke_ram(4'hE, 8'd28); poke_ram(4'hF, 8'd14);
      for (int i = 0; i < 17; i++) begin
         idle(tbl[i].cw);
         check($sformatf("prog[%0d].bus", i), last_bus, tbl[i].exp_bus);
         check($sformatf("prog[%0d].insn", i), insn, tbl[i].exp_insn);
         check($sformatf("prog[%0d].out_val", i), out_val, tbl[i].exp_out);
         check($sformatf("prog[%0d].out_valid", i), out_valid, tbl[i].exp_ov);
         check($sformatf("prog[%0d].flag_c", i), flag_c, tbl[i].exp_c);
         check($sformatf("prog[%0d].flag_z", i), flag_z, tbl[i].exp_z);
         check($sformatf("prog[%0d].halted", i), halted, tbl[i].exp_halt);
      end
      cycle(15'h0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);

      // Subtract: 5-5 and 3-5.
      load_via_ram(K_AI, 8'h05); load_via_ram(K_BI, 8'h05);
      idle(K_SUB | K_SUMO | K_AI);
      check("sub0.flag_z", flag_z, 1'b1);
      check("sub0.flag_c", flag_c, 1'b1);
      idle(K_AO); check("sub0.a", last_bus, 8'h00);
      load_via_ram(K_AI, 8'h03); load_via_ram(K_BI, 8'h05);
      idle(K_SUB | K_SUMO | K_AI);
      check("sub1.flag_z", flag_z, 1'b0);
      check("sub1.flag_c", flag_c, 1'b0);
      idle(K_AO); check("sub1.a", last_bus, 8'hFE);

      // Overflow and PC wrap.
      load_via_ram(K_AI, 8'hFF); load_via_ram(K_BI, 8'h01);
      idle(K_SUMO | K_AI);
      check("ovf.flag_c", flag_c, 1'b1);
      check("ovf.flag_z", flag_z, 1'b1);
      idle(K_AO); check("ovf.a", last_bus, 8'h00);
      load_via_ram(K_II, 8'h6F);
      idle(K_IO | K_J);
      idle(K_CO); check("wrap.pc15", last_bus, 8'h0F);
      idle(K_CE);
      idle(K_CO); check("wrap.pc0", last_bus, 8'h00);
      load_via_ram(K_II, 8'h67);
      idle(K_IO | K_CE | K_J);
      idle(K_CO); check("jmp.pc7", last_bus, 8'h07);

      // Bus conflict, then ri colliding with the loader.
      load_via_ram(K_II, 8'h63);
      idle(K_IO | K_J);
      load_via_ram(K_AI, 8'h55);
      idle(K_CO | K_AO);
      check("conf.bus", last_bus, 8'h03);
      check("conf.flag", last_conf, 1'b1);
      cycle(K_RI | K_CO, 1'b1, m_mar, 8'hC3, 1'b1, 1'b1);
      idle(K_RO); check("ri_vs_prog.ram", last_bus, 8'hC3);

      // Halt with a same-cycle load, ignored controls afterwards, then reset.
      poke_ram(m_mar, 8'h09);
      cycle(K_HLT | K_AI | K_RO, 1'b1, m_mar, 8'h33, 1'b1, 1'b1);
      check("hlt.a", dut.r_a, 8'h09);
      check("hlt.halted", halted, 1'b1);
      idle(K_AI | K_RO | K_CE);
      check("hlt.bus_idle", last_bus, 8'h00);
      check("hlt.a_kept", dut.r_a, 8'h09);
      check("hlt.still", halted, 1'b1);
      cycle(15'h0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
      check("hlt.rst_halted", halted, 1'b0);
      idle(K_AO); check("hlt.rst_a", last_bus, 8'h00);
      idle(K_RO); check("hlt.prog_while_halted", last_bus, 8'h33);

      // Random control words scored against the model.
      for (int i = 0; i < 800; i++) begin
         logic [14:0] c;
         logic        pwe, rn;
         c = 15'($urandom);
         c = c & ~K_HLT;
         if ($urandom_range(0, 47) == 0) c = c | K_HLT;
         pwe = ($urandom_range(0, 3) == 0);
         rn  = ($urandom_range(0, 59) != 0);
         if (m_halt && $urandom_range(0, 5) == 0) rn = 1'b0;
         cycle(c, pwe, 4'($urandom), 8'($urandom), rn, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
Execution datapath for the 8-bit microcoded CPU; it is the receiving end of the control-word interface.
- It consumes one control word per clock (hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j) and returns the fetched instruction byte to the controller.
- Contents: shared 8-bit bus, 4-bit PC, 4-bit MAR, 16x8 RAM, IR, A, B, adder/subtractor with flags, output register, halt latch.
- The controller drives control lines off the falling edge; this block acts on the rising edge.

Parameters:
- RAM_DEPTH, 16, RAM words; fixed at 16 because addresses are 4 bits.
- BUS_W, 8, data/bus width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j  in  1 each  control word.
- prog_we  in  1  external RAM write strobe (program loader).
- prog_addr  in  4  loader address.
- prog_data  in  8  loader data.
- insn  out  8  IR contents, to the controller.
- bus  out  8  current bus value (debug).
- out_val  out  8  output register.
- out_valid  out  1  one-cycle pulse when out_val is loaded.
- flag_c, flag_z  out  1  carry / zero flags.
- halted  out  1  sticky halt status.
- bus_conflict  out  1  more than one bus driver asserted.

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc, mar, ir, a, b, out_val ← 0.
  - flag_c, flag_z, halted, out_valid ← 0.
  - RAM is not cleared.
  - Reset overrides every control input and works mid-instruction.
- Bus (combinational):
  - Driver priority co > ro > io > ao > sumo.
  - co drives {4'h0, pc}; ro drives ram[mar]; io drives {4'h0, ir[3:0]}; ao drives a; sumo drives alu_res.
  - With no driver the bus is 8'h00.
  - bus_conflict = more than one of {co, ro, io, ao, sumo} asserted; bus still follows the priority order.
  - All drivers are ignored while halted: bus = 0, bus_conflict = 0.
- ALU (combinational):
  - {carry, alu_res} = a + (sub ? ~b : b) + sub, computed 9 bits wide.
  - Each cycle sumo=1 and not halted: flag_c ← carry, flag_z ← (alu_res == 0). Otherwise the flags hold.
- Posedge actions (when not halted), all sampling pre-edge values:
  - mi: mar ← bus[3:0].
  - ri: ram[mar] ← bus.
  - ii: ir ← bus.
  - ai: a ← bus.
  - bi: b ← bus.
  - oi: out_val ← bus, out_valid ← 1. out_valid is 0 in every other cycle.
  - ce: pc ← pc+1 mod 16; 15 wraps to 0.
  - j: pc ← bus[3:0]; j overrides ce.
- Self-loops are well defined: ri with ro rewrites the same value; ai with ao, or ai with sumo, loads from pre-edge a/b.
- Halt:
  - hlt=1 sets halted at the posedge.
  - Other controls in that same cycle still take effect.
  - From the next cycle on, all control inputs are ignored until reset.
- Program load:
  - prog_we writes ram[prog_addr] ← prog_data in any cycle, halted or not.
  - If ri and prog_we occur in the same cycle, prog_we wins and the ri write is dropped.
- RAM reads are asynchronous (ro sees the current mar). Read-before-write: a same-cycle write is visible from the next cycle.
- Latency: any load is visible one cycle after its control cycle; insn updates the cycle after ii.

Test Plan:
1. Reset: hold rst_n=0 for one cycle with ai=1 and the bus driven → pc=0, insn=0, a=0, out_val=0, halted=0; RAM contents preserved.
2. Program run: load ram[0..3] = 0x1E, 0x2F, 0xE0, 0xF0 and ram[14]=28, ram[15]=14 via prog_we, then drive the LDA/ADD/OUT/HLT microsteps → out_val=42 with a single out_valid pulse, flag_c=0, flag_z=0, halted=1, pc=4.
3. Subtract: a=5, b=5; sub=1, sumo=1, ai=1 → a=0x00, flag_z=1, flag_c=1. Then a=3, b=5 subtract → a=0xFE, flag_c=0, flag_z=0.
4. Overflow and PC wrap:
   - a=0xFF, b=0x01 add → a=0x00, flag_c=1, flag_z=1.
   - pc=15 with ce → pc=0.
   - ce with j while bus=0x07 (via io, ir=0x67) → pc=7.
5. Bus conflict: co=1 and ao=1 with pc=3, a=0x55 → bus=0x03, bus_conflict=1. Then ri and prog_we together → the prog_data value is stored.
6. Halt and reset mid-run:
   - hlt=1 with ai=1, bus=0x09 → a=9, halted=1.
   - Next cycle ai with a different bus value → a stays 9.
   - rst_n=0 → halted=0, a=0.
